// File: rtl/if_stage_if.sv
// IF-stage bus bundle: decode control, imem port and IF/ID outputs.
// master = fetch stage, slave = surrounding pipeline and memory.
interface if_stage_if #(
  parameter int WIDTH = 16,
  parameter int PC_W  = 32
);
  logic             fetch_pc_enable;
  logic             load_use;
  logic [1:0]       pc_sel;
  logic [PC_W-1:0]  pc_jmp;
  logic [PC_W-1:0]  pc_pop;
  logic [PC_W-1:0]  imem_addr;
  logic [WIDTH-1:0] imem_data;
  logic [WIDTH-1:0] instr_out;
  logic [PC_W-1:0]  pc_out;
  logic             valid_out;
  logic             booting;

  modport master (
    input  fetch_pc_enable, load_use, pc_sel,
    input  pc_jmp, pc_pop, imem_data,
    output imem_addr, instr_out, pc_out,
    output valid_out, booting
  );

  modport slave (
    output fetch_pc_enable, load_use, pc_sel,
    output pc_jmp, pc_pop, imem_data,
    input  imem_addr, instr_out, pc_out,
    input  valid_out, booting
  );
endinterface

// File: rtl/if_stage.sv
// Fetch stage + IF/ID register; boots PC from imem[1:0].
// IF_PERF_CNT_EN adds saturating stall/flush counters.
module if_stage #(
  parameter int               WIDTH     = 16,
  parameter int               PC_W      = 32,
  parameter logic [WIDTH-1:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
`endif
  if_stage_if.master  bus
);

  typedef enum logic [1:0] {
    BOOT_LO,
    BOOT_HI,
    RUN
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PC_W-1:0]  pc;
  logic [WIDTH-1:0] boot_lo;
  logic             redirect;
  logic             stall;

  // State register; booting is registered alongside it
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= BOOT_LO;
      bus.booting <= 1'b1;
    end else begin
      state       <= state_nxt;
      bus.booting <= (state_nxt != RUN);
    end
  end

  // Next state, fetch address and branch selection
  always_comb begin
    state_nxt     = state;
    redirect      = 1'b0;
    stall         = 1'b0;
    bus.imem_addr = pc;
    unique case (state)
      BOOT_LO: begin
        bus.imem_addr = '0;
        state_nxt     = BOOT_HI;
      end
      BOOT_HI: begin
        bus.imem_addr = PC_W'(1);
        state_nxt     = RUN;
      end
      RUN: begin
        redirect = (bus.pc_sel == 2'b01) ||
                   (bus.pc_sel == 2'b10);
        stall    = !redirect &&
                   (bus.load_use ||
                    !bus.fetch_pc_enable);
      end
      default: state_nxt = BOOT_LO;
    endcase
  end

  // PC, boot latch and IF/ID register
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc            <= '0;
      boot_lo       <= '0;
      bus.instr_out <= NOP_INSTR;
      bus.pc_out    <= '0;
      bus.valid_out <= 1'b0;
    end else begin
      unique case (state)
        BOOT_LO: boot_lo <= bus.imem_data;
        BOOT_HI: pc <= PC_W'({bus.imem_data, boot_lo});
        RUN: begin
          if (redirect) begin
            pc            <= (bus.pc_sel == 2'b01) ?
                             bus.pc_jmp : bus.pc_pop;
            bus.instr_out <= NOP_INSTR;
            bus.pc_out    <= '0;
            bus.valid_out <= 1'b0;
          end else if (!stall) begin
            pc            <= pc + PC_W'(1);
            bus.instr_out <= bus.imem_data;
            bus.pc_out    <= pc + PC_W'(1);
            bus.valid_out <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  // Saturating stall / redirect event counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (redirect && flush_cnt != 32'hFFFF_FFFF)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a cycle-level reference model.
// Build with IF_PERF_CNT_EN to also check the counters.
module tb_if_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  if_stage_if bus ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  if_stage dut (
    .clk       (clk),
    .rst       (rst),
`ifdef IF_PERF_CNT_EN
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
`endif
    .bus       (bus)
  );

  logic [15:0] mem [0:1023];
  assign bus.imem_data = mem[bus.imem_addr[9:0]];

  int total = 0;
  int bad   = 0;

  // reference model: boot step 0/1/2 (2 = running)
  int          m_step = 0;
  logic [15:0] m_lo;
  logic [31:0] m_pc;
  logic [15:0] m_instr;
  logic [31:0] m_pcout;
  logic        m_valid;
  bit          chk_en = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_step  = 0;
      m_lo    = '0;
      m_pc    = '0;
      m_instr = 16'h0000;
      m_pcout = '0;
      m_valid = 1'b0;
      chk_en  = 1;
    end else if (m_step == 0) begin
      m_lo   = mem[0];
      m_step = 1;
    end else if (m_step == 1) begin
      m_pc   = {mem[1], m_lo};
      m_step = 2;
    end else if (bus.pc_sel == 2'd1) begin
      m_pc = bus.pc_jmp;
      m_instr = 16'h0000; m_pcout = '0; m_valid = 1'b0;
    end else if (bus.pc_sel == 2'd2) begin
      m_pc = bus.pc_pop;
      m_instr = 16'h0000; m_pcout = '0; m_valid = 1'b0;
    end else if (bus.load_use || !bus.fetch_pc_enable) begin
    end else begin
      m_instr = mem[m_pc[9:0]];
      m_pcout = m_pc + 32'd1;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd1;
    end
  end

  function automatic logic [31:0] m_addr();
    if (m_step == 0) return 32'd0;
    if (m_step == 1) return 32'd1;
    return m_pc;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_addr",  bus.imem_addr, m_addr());
      chk("m_instr", 32'(bus.instr_out), 32'(m_instr));
      chk("m_pcout", bus.pc_out, m_pcout);
      chk("m_valid", 32'(bus.valid_out), 32'(m_valid));
      chk("m_boot",  32'(bus.booting), 32'(m_step != 2));
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'hA000 ^ 16'(i);
    mem[0]    = 16'h0010;
    mem[1]    = 16'h0000;
    mem[16]   = 16'h1234;
    bus.fetch_pc_enable = 1'b1;
    bus.load_use = 1'b0;
    bus.pc_sel   = 2'b00;
    bus.pc_jmp   = '0;
    bus.pc_pop   = '0;

    rst = 1'b0;
    cyc(); cyc();
    chk("rst_boot",  32'(bus.booting), 32'd1);
    chk("rst_valid", 32'(bus.valid_out), 32'd0);
    chk("rst_addr",  bus.imem_addr, 32'h0);
    rst = 1'b1;

    cyc();
    chk("boot1", 32'(bus.booting), 32'd1);
    chk("boot1_addr", bus.imem_addr, 32'h1);
    cyc();
    chk("boot2", 32'(bus.booting), 32'd0);
    chk("run_addr", bus.imem_addr, 32'h10);
    cyc();
    chk("first_instr", 32'(bus.instr_out), 32'h1234);
    chk("first_pcout", bus.pc_out, 32'h11);
    chk("first_valid", 32'(bus.valid_out), 32'd1);
    cyc();
    chk("seq_instr", 32'(bus.instr_out), 32'hA011);
    chk("seq_pcout", bus.pc_out, 32'h12);

    bus.load_use = 1'b1;
    cyc(); cyc();
    chk("stall_instr", 32'(bus.instr_out), 32'hA011);
    chk("stall_pcout", bus.pc_out, 32'h12);
    chk("stall_addr", bus.imem_addr, 32'h12);
    bus.load_use = 1'b0;
    cyc();
    chk("rel_instr", 32'(bus.instr_out), 32'hA012);
    chk("rel_pcout", bus.pc_out, 32'h13);

    bus.fetch_pc_enable = 1'b0;
    cyc();
    chk("fen_instr", 32'(bus.instr_out), 32'hA012);
    chk("fen_addr", bus.imem_addr, 32'h13);
    bus.fetch_pc_enable = 1'b1;

    bus.pc_sel = 2'b01;
    bus.pc_jmp = 32'h200;
    bus.load_use = 1'b1;
    cyc();
    chk("jmp_addr", bus.imem_addr, 32'h200);
    chk("jmp_valid", 32'(bus.valid_out), 32'd0);
    chk("jmp_instr", 32'(bus.instr_out), 32'h0);
    chk("jmp_pcout", bus.pc_out, 32'h0);
    bus.pc_sel = 2'b00;
    bus.load_use = 1'b0;
    cyc();
    chk("jmp_tgt", 32'(bus.instr_out), 32'hA200);
    chk("jmp_ret", bus.pc_out, 32'h201);

    bus.pc_sel = 2'b11;
    cyc();
    chk("rsv_instr", 32'(bus.instr_out), 32'hA201);
    chk("rsv_valid", 32'(bus.valid_out), 32'd1);

    bus.pc_sel = 2'b10;
    bus.pc_pop = 32'hFFFF_FFFF;
    cyc();
    chk("pop_addr", bus.imem_addr, 32'hFFFF_FFFF);
    chk("pop_valid", 32'(bus.valid_out), 32'd0);
    bus.pc_sel = 2'b00;
    cyc();
    chk("wrap_addr", bus.imem_addr, 32'h0);
    chk("wrap_pcout", bus.pc_out, 32'h0);
    chk("wrap_instr", 32'(bus.instr_out), 32'hA3FF);

`ifdef IF_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, 32'd3);
    chk("flush_cnt", flush_cnt, 32'd2);
`endif

    rst = 1'b0;
    bus.pc_sel = 2'b01;
    cyc();
    chk("mid_boot", 32'(bus.booting), 32'd1);
    chk("mid_valid", 32'(bus.valid_out), 32'd0);
    chk("mid_addr", bus.imem_addr, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("stall_clr", stall_cnt, 32'd0);
    chk("flush_clr", flush_cnt, 32'd0);
`endif
    rst = 1'b1;
    bus.load_use = 1'b1;
    cyc(); cyc();
    chk("reboot_addr", bus.imem_addr, 32'h10);
    bus.pc_sel = 2'b00;
    bus.load_use = 1'b0;
    cyc();
    chk("reboot_instr", 32'(bus.instr_out), 32'h1234);
    chk("reboot_pcout", bus.pc_out, 32'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
